carrier_run_controller: RTL and testbench

Sequences the level-shifted carrier generator in the modulator chain. Owns its enable and freq_div inputs. Starts and stops it only on clean carrier-period boundaries, marked by sync_pulse. Takes new divider values from a host valid/ready interface and applies them at a boundary, and forces the generator off on a fault or a lost sync.

---
 rtl/carrier_run_controller.sv | 160 ++++++++++++++++
 tb/tb_carrier_run_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_run_controller.sv
// carrier_run_controller: starts/stops the carrier generator and applies divider updates on sync boundaries.
// Optional sync watchdog is built in when CARRIER_WDOG_EN is defined.
module carrier_run_controller #(
   parameter int COUNTER_WIDTH = 16,
   parameter int DEFAULT_DIV   = 100,
   parameter int MIN_DIV       = 4,
   parameter int ARM_CYCLES    = 8,
   parameter int WDOG_MARGIN   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     fault_in,
   input  logic                     fault_clr,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [COUNTER_WIDTH-1:0] cfg_freq_div,
   input  logic                     sync_pulse,
   output logic                     gen_enable,
   output logic [COUNTER_WIDTH-1:0] gen_freq_div,
   output logic [2:0]               state,
   output logic                     upd_done,
   output logic                     cfg_err,
   output logic                     wdog_trip,
   output logic [15:0]              period_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_STOP  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t                   st;
   logic [COUNTER_WIDTH-1:0] arm_cnt;
   logic [COUNTER_WIDTH-1:0] shadow;
   logic                     pending;
   logic                     accept;
   logic                     cfg_ok;
   logic                     running;
   logic                     wd_hit;

   assign state     = st;
   assign running   = (st == S_RUN) || (st == S_STOP);
   assign cfg_ready = !pending && (st != S_FAULT);
   assign accept    = cfg_valid && cfg_ready;
   assign cfg_ok    = cfg_freq_div >= COUNTER_WIDTH'(MIN_DIV);

`ifdef CARRIER_WDOG_EN
   localparam int WW = COUNTER_WIDTH + 2;
   logic [WW-1:0] wd_cnt;
   logic [WW-1:0] wd_limit;

   // wd_cnt holds cycles elapsed since the last sync (or RUN entry); trip lands as it reaches the limit
   assign wd_limit = {1'b0, gen_freq_div, 1'b0} + WW'(WDOG_MARGIN);
   assign wd_hit   = running && !sync_pulse && ((wd_cnt + WW'(1)) >= wd_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= WW'(1);
      else if (!running || sync_pulse)
         wd_cnt <= WW'(1);
      else
         wd_cnt <= wd_cnt + WW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wdog_trip <= 1'b0;
      else if (wd_hit)
         wdog_trip <= 1'b1;
      else if (st == S_FAULT && fault_clr && !fault_in)
         wdog_trip <= 1'b0;
   end
`else
   assign wd_hit    = 1'b0;
   assign wdog_trip = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= S_IDLE;
         gen_enable   <= 1'b0;
         gen_freq_div <= COUNTER_WIDTH'(DEFAULT_DIV);
         arm_cnt      <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         upd_done     <= 1'b0;
         cfg_err      <= 1'b0;
         period_cnt   <= '0;
      end else begin
         upd_done <= 1'b0;
         cfg_err  <= 1'b0;

         if (accept) begin
            if (!cfg_ok)
               cfg_err <= 1'b1;
            else if (st == S_IDLE || st == S_ARM) begin
               gen_freq_div <= cfg_freq_div;
               upd_done     <= 1'b1;
            end else begin
               shadow  <= cfg_freq_div;
               pending <= 1'b1;
            end
         // a shadow left over after STOP->IDLE lands at once, since the generator is already off
         end else if (pending && st != S_FAULT &&
                      (sync_pulse || st == S_IDLE || st == S_ARM)) begin
            gen_freq_div <= shadow;
            upd_done     <= 1'b1;
            pending      <= 1'b0;
         end

         if (running && sync_pulse)
            period_cnt <= period_cnt + 16'd1;

         if (fault_in || wd_hit) begin
            st         <= S_FAULT;
            gen_enable <= 1'b0;
         end else begin
            case (st)
               S_IDLE:
                  if (start && !stop) begin
                     st         <= S_ARM;
                     period_cnt <= '0;
                     arm_cnt    <= COUNTER_WIDTH'(ARM_CYCLES - 1);
                  end
               S_ARM:
                  if (stop)
                     st <= S_IDLE;
                  else if (arm_cnt == '0) begin
                     st         <= S_RUN;
                     gen_enable <= 1'b1;
                  end else
                     arm_cnt <= arm_cnt - 1'b1;
               S_RUN:
                  if (stop)
                     st <= S_STOP;
               S_STOP:
                  if (sync_pulse) begin
                     st         <= S_IDLE;
                     gen_enable <= 1'b0;
                  end
               S_FAULT:
                  if (fault_clr) begin
                     st      <= S_IDLE;
                     pending <= 1'b0;
                  end
               default: begin
                  st         <= S_IDLE;
                  gen_enable <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_carrier_run_controller.sv
// Bench for carrier_run_controller: directed vectors, upd_done/cfg_err events checked via a scoreboard queue.
module tb_carrier_run_controller;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, stop, fault_in, fault_clr;
   logic          cfg_valid, cfg_ready;
   logic [CW-1:0] cfg_freq_div;
   logic          sync_pulse;
   logic          gen_enable;
   logic [CW-1:0] gen_freq_div;
   logic [2:0]    state;
   logic          upd_done, cfg_err, wdog_trip;
   logic [15:0]   period_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit            is_err;
      logic [CW-1:0] val;
   } exp_t;
   exp_t sb[$];

   carrier_run_controller dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .fault_in(fault_in), .fault_clr(fault_clr),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq_div(cfg_freq_div),
      .sync_pulse(sync_pulse), .gen_enable(gen_enable), .gen_freq_div(gen_freq_div),
      .state(state), .upd_done(upd_done), .cfg_err(cfg_err),
      .wdog_trip(wdog_trip), .period_cnt(period_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_upd(input logic [CW-1:0] v);
      exp_t e;
      e.is_err = 1'b0;
      e.val    = v;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.val    = '0;
      sb.push_back(e);
   endtask

   task automatic send_cfg(input logic [CW-1:0] v, input logic with_sync);
      cfg_valid    = 1'b1;
      cfg_freq_div = v;
      sync_pulse   = with_sync;
      cyc(1);
      cfg_valid  = 1'b0;
      sync_pulse = 1'b0;
   endtask

   task automatic pulse_sync();
      sync_pulse = 1'b1;
      cyc(1);
      sync_pulse = 1'b0;
   endtask

   task automatic start_to_run();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(8);
   endtask

   // Scoreboard monitor: every upd_done/cfg_err pulse must match the next expected event
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && (upd_done || cfg_err)) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: upd_done=%0b cfg_err=%0b div=%0d, expected no event",
                     upd_done, cfg_err, gen_freq_div);
         end else begin
            e = sb.pop_front();
            if (e.is_err) begin
               if (!cfg_err || upd_done) begin
                  fails++;
                  $display("FAIL sb_cfg_err: upd_done=%0b cfg_err=%0b, expected cfg_err only",
                           upd_done, cfg_err);
               end
            end else if (!upd_done || cfg_err || gen_freq_div !== e.val) begin
               fails++;
               $display("FAIL sb_upd: upd_done=%0b cfg_err=%0b div=%0d, expected upd_done div=%0d",
                        upd_done, cfg_err, gen_freq_div, e.val);
            end
         end
      end
   end

   initial begin : guard
      #400000;
      $display("FAIL global_timeout: sim time exceeded, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 0; stop = 0; fault_in = 0; fault_clr = 0;
      cfg_valid = 0; cfg_freq_div = '0; sync_pulse = 0;
      #12;
      chk("rst_gen_enable", gen_enable, 0);
      chk("rst_gen_freq_div", gen_freq_div, 100);
      chk("rst_state", state, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_period_cnt", period_cnt, 0);
      chk("rst_wdog_trip", wdog_trip, 0);
      chk("rst_pulses", {upd_done, cfg_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(2);

      // start: 8 ARM cycles, RUN and gen_enable on the 9th cycle
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("arm_period_cnt_clr", period_cnt, 0);
      for (int i = 1; i <= 8; i++) begin
         chk("arm_state", state, 1);
         chk("arm_gen_enable", gen_enable, 0);
         cyc(1);
      end
      chk("run_state", state, 2);
      chk("run_gen_enable", gen_enable, 1);
      chk("run_div", gen_freq_div, 100);

      // start in RUN is ignored
      start = 1'b1; cyc(1); start = 1'b0;
      chk("run_start_ignored", state, 2);

      // deferred update in RUN
      push_upd(200);
      send_cfg(200, 1'b0);
      chk("pend_cfg_ready", cfg_ready, 0);
      chk("pend_div_hold", gen_freq_div, 100);
      cyc(3);
      chk("pend_div_hold2", gen_freq_div, 100);
      pulse_sync();
      chk("upd_div_200", gen_freq_div, 200);
      chk("upd_cfg_ready", cfg_ready, 1);

      // accept coinciding with sync waits for the following sync
      push_upd(50);
      send_cfg(50, 1'b1);
      chk("same_sync_hold", gen_freq_div, 200);
      chk("same_sync_ready", cfg_ready, 0);
      cyc(2);
      chk("same_sync_hold2", gen_freq_div, 200);
      pulse_sync();
      chk("same_sync_apply", gen_freq_div, 50);

      // below MIN_DIV rejected, MIN_DIV itself accepted
      push_err();
      send_cfg(3, 1'b0);
      chk("err_cfg_ready", cfg_ready, 1);
      chk("err_div_unchanged", gen_freq_div, 50);
      cyc(1);
      chk("err_div_unchanged2", gen_freq_div, 50);
      push_upd(4);
      send_cfg(4, 1'b0);
      pulse_sync();
      chk("min_div_apply", gen_freq_div, 4);

      // stop mid-period: enable held until the next sync
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("stop_state", state, 3);
      chk("stop_enable_held", gen_enable, 1);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("stop_start_ignored", state, 3);
      cyc(2);
      chk("stop_enable_held2", gen_enable, 1);
      pulse_sync();
      chk("stop_idle", state, 0);
      chk("stop_enable_off", gen_enable, 0);
      chk("period_cnt", period_cnt, 5);

      // IDLE: stop ignored, immediate cfg update
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("idle_stop_ignored", state, 0);
      push_upd(120);
      send_cfg(120, 1'b0);
      chk("idle_cfg_apply", gen_freq_div, 120);

      // stop during ARM returns to IDLE
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("arm_stop_idle", state, 0);
      chk("arm_stop_enable", gen_enable, 0);

      // fault beats stop; fault_clr only honoured once fault_in drops
      start_to_run();
      chk("fault_pre_run", state, 2);
      fault_in = 1'b1; stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("fault_state", state, 4);
      chk("fault_enable", gen_enable, 0);
      chk("fault_cfg_ready", cfg_ready, 0);
      fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
      chk("fault_clr_ignored", state, 4);
      fault_in = 1'b0;
      cyc(2);
      chk("fault_hold", state, 4);
      fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
      chk("fault_exit", state, 0);
      chk("fault_exit_wdog", wdog_trip, 0);
      chk("fault_exit_ready", cfg_ready, 1);

`ifdef CARRIER_WDOG_EN
      begin : wdog_test
         int n;
         push_upd(100);
         send_cfg(100, 1'b0);
         start_to_run();
         cyc(5);
         pulse_sync();
         n = 1;
         while (!wdog_trip && n < 400) begin
            cyc(1);
            n++;
         end
         chk("wdog_cycles", n, 216);
         chk("wdog_state", state, 4);
         chk("wdog_enable", gen_enable, 0);
         fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
         chk("wdog_clear", wdog_trip, 0);
         chk("wdog_exit", state, 0);
      end
`endif

      // asynchronous reset while running drops gen_enable before the next edge
      start_to_run();
      chk("pre_rst_enable", gen_enable, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_enable", gen_enable, 0);
      chk("async_rst_state", state, 0);
      cyc(1);
      rst = 1'b0;
      cyc(2);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
